mult_seq: RTL and testbench

Multi-cycle radix-2 shift-add multiplier for MULT/MULTU. It answers the same valid/sign/stall request protocol the EXE-stage ALU already uses toward the divider, and it replaces the single-cycle 32x32 combinational multiply. It returns a 64-bit {HI,LO} product that the ALU forwards on hilo_o. While the product is being formed, it holds the pipeline through stall.

---
 rtl/mult_seq_pkg.sv | 22 ++
 rtl/mult_seq_if.sv | 41 ++++
 rtl/mult_seq.sv | 125 ++++++++++++
 tb/tb_mult_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq_pkg
//  Purpose  : Shared types and constants for the sequential MULT/MULTU unit.
//             Holds the state encoding and the default operand geometry.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mult_seq_pkg;

   localparam int unsigned c_mult_width  = 32;  // operand width
   localparam int unsigned c_mult_cnt_w  = 5;   // log2(c_mult_width)
   localparam int unsigned c_mult_cycles = 32;  // shift-add iterations

   typedef enum logic [1:0] {
      MULT_IDLE = 2'd0,
      MULT_BUSY = 2'd1,
      MULT_DONE = 2'd2
   } mult_state_e;

endpackage : mult_seq_pkg
`default_nettype wire

// File: rtl/mult_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq_if
//  Purpose  : Request/response bundle between the EXE-stage ALU (master) and
//             the sequential multiplier (slave).
//  Signals  : a, b      - multiplicand (rs) / multiplier (rt)
//             valid     - MULT/MULTU present in EXE
//             sign      - 1 = MULT (signed), 0 = MULTU
//             annul     - flush of the EXE instruction
//             stall     - hold request back to the pipeline
//             result    - {HI,LO} product
//             ready     - one-cycle pulse when result is valid
//  Revision : 1.0  initial release
// ============================================================================
interface mult_seq_if
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = c_mult_width
);

   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               valid;
   logic               sign;
   logic               annul;
   logic               stall;
   logic [2*WIDTH-1:0] result;
   logic               ready;

   modport master (
      output a, b, valid, sign, annul,
      input  stall, result, ready
   );

   modport slave (
      input  a, b, valid, sign, annul,
      output stall, result, ready
   );

endinterface : mult_seq_if
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq
//  Purpose  : Radix-2 shift-add multiplier for MULT/MULTU. Works on operand
//             magnitudes and applies the sign once at the end, so the only
//             arithmetic is a (WIDTH+1)-bit adder and a final 2*WIDTH negate.
//             Latency is 33 cycles from request to the ready pulse.
//  Ports    : clk  - core clock
//             rst  - synchronous reset, active low
//             bus  - mult_seq_if slave side (a, b, valid, sign, annul in;
//                    stall, result, ready out)
//  Revision : 1.0  initial release
// ============================================================================
module mult_seq
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = c_mult_width,
   parameter int CNT_W = c_mult_cnt_w
) (
   input  wire logic clk,
   input  wire logic rst,
   mult_seq_if.slave bus
);

   mult_state_e        state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH:0]     hi_q,     hi_d;      // one guard bit for the adder carry
   logic [WIDTH-1:0]   lo_q,     lo_d;
   logic [WIDTH-1:0]   mcand_q,  mcand_d;
   logic               neg_q,    neg_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_step_hi;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_last;

   // Magnitudes: -2^(WIDTH-1) negates to itself, which read unsigned is the
   // correct magnitude, so no extra bit is needed.
   assign w_a_mag = (bus.sign & bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
   assign w_b_mag = (bus.sign & bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;

   assign w_sum     = hi_q + {1'b0, mcand_q};
   assign w_step_hi = lo_q[0] ? w_sum : hi_q;
   assign w_last    = (cnt_q == CNT_W'(WIDTH - 1));

   // Product as it stands after this cycle's shift; only consumed on the
   // final step.
   assign w_prod = {hi_d[WIDTH-1:0], lo_d};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      neg_d    = neg_q;
      result_d = result_q;

      if (bus.annul) begin
         // Flush wins over everything; result is left untouched.
         state_d = MULT_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            MULT_IDLE: begin
               if (bus.valid) begin
                  mcand_d = w_a_mag;
                  hi_d    = '0;
                  lo_d    = w_b_mag;
                  neg_d   = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  cnt_d   = '0;
                  state_d = MULT_BUSY;
               end
            end
            MULT_BUSY: begin
               // Conditional add, then shift {hi,lo} right with a zero in.
               hi_d  = {1'b0, w_step_hi[WIDTH:1]};
               lo_d  = {w_step_hi[0], lo_q[WIDTH-1:1]};
               cnt_d = cnt_q + CNT_W'(1);
               if (w_last) begin
                  result_d = neg_q ? ('0 - w_prod) : w_prod;
                  state_d  = MULT_DONE;
               end
            end
            MULT_DONE: begin
               state_d = MULT_IDLE;
            end
            default: begin
               state_d = MULT_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= MULT_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   // Stall is combinational so the pipeline holds in the request cycle; it
   // drops in DONE, which is the cycle the pipeline advances.
   assign bus.stall  = bus.valid & ~bus.annul & (state_q != MULT_DONE);
   assign bus.ready  = (state_q == MULT_DONE);
   assign bus.result = result_q;

endmodule : mult_seq
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_seq
//  Purpose  : Scoreboard bench for mult_seq. The driver pushes the expected
//             product when a request is issued and sets the per-cycle
//             expected stall/ready; a monitor on the falling edge compares.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_seq;
   import mult_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mult_seq_if #(.WIDTH(32)) bus ();

   mult_seq #(
      .WIDTH (32),
      .CNT_W (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [63:0] exp_q[$];
   logic        mon_en    = 1'b0;
   logic        exp_stall = 1'b0;
   logic        exp_ready = 1'b0;
   logic        hold_chk  = 1'b0;
   logic        final_chk = 1'b0;
   logic [63:0] hold_val  = '0;
   logic [63:0] last_res  = '0;
   int          n_pass    = 0;
   int          n_total   = 0;

   // Monitor / scoreboard
   initial begin
      logic [63:0] want;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            n_total++;
            if (bus.stall === exp_stall) n_pass++;
            else $display("FAIL stall t=%0t got=%b exp=%b", $time, bus.stall, exp_stall);

            n_total++;
            if (bus.ready === exp_ready) n_pass++;
            else $display("FAIL ready t=%0t got=%b exp=%b", $time, bus.ready, exp_ready);

            if (bus.ready === 1'b1) begin
               n_total++;
               if (exp_q.size() == 0) begin
                  $display("FAIL unexpected_ready t=%0t result=%h", $time, bus.result);
               end else begin
                  want = exp_q.pop_front();
                  if (bus.result === want) n_pass++;
                  else $display("FAIL result t=%0t got=%h exp=%h", $time, bus.result, want);
               end
            end

            if (hold_chk) begin
               n_total++;
               if (bus.result === hold_val) n_pass++;
               else $display("FAIL result_hold t=%0t got=%h exp=%h", $time, bus.result, hold_val);
            end

            if (final_chk) begin
               n_total++;
               if (exp_q.size() == 0) n_pass++;
               else $display("FAIL pending_results got=%0d exp=0", exp_q.size());
            end
         end
      end
   end

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.valid = 1'b0;
         bus.annul = 1'b0;
         rst       = 1'b1;
         exp_stall = 1'b0;
         exp_ready = 1'b0;
         hold_chk  = 1'b1;
         hold_val  = last_res;
         adv();
      end
      hold_chk = 1'b0;
   endtask

   // abort_kind: 0 = none, 1 = annul at abort_cyc, 2 = reset at abort_cyc.
   // chg_cyc >= 0 replaces a with chg_a from that cycle on.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp_res,
                         input int abort_kind, input int abort_cyc,
                         input int chg_cyc, input logic [31:0] chg_a);
      for (int c = 0; c <= 33; c++) begin
         rst       = 1'b1;
         bus.valid = 1'b1;
         bus.annul = 1'b0;
         bus.sign  = s;
         bus.a     = (chg_cyc >= 0 && c >= chg_cyc) ? chg_a : a;
         bus.b     = b;
         exp_stall = (c != 33);
         exp_ready = (c == 33);
         hold_chk  = 1'b0;
         if (c == 0 && abort_kind == 0) exp_q.push_back(exp_res);
         if (abort_kind != 0 && c == abort_cyc) begin
            if (abort_kind == 1) begin
               bus.annul = 1'b1;
            end else begin
               rst       = 1'b0;
               bus.valid = 1'b0;
            end
            exp_stall = 1'b0;
            exp_ready = 1'b0;
            hold_chk  = 1'b1;
            hold_val  = last_res;
            adv();
            hold_chk  = 1'b0;
            return;
         end
         adv();
      end
      if (abort_kind == 0) last_res = exp_res;
   endtask

   initial begin
      rst       = 1'b0;
      bus.valid = 1'b0;
      bus.annul = 1'b0;
      bus.sign  = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) adv();
      mon_en = 1'b1;
      adv();                     // still in reset, monitor checks stall/ready
      idle(2);                   // out of reset: result must read 0

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 0, -1, '0);
      idle(1);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, -1, '0);
      idle(1);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 0, -1, '0);
      idle(1);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 0, 0, -1, '0);
      idle(1);
      run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0, -1, '0);
      idle(1);
      run_op(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, 0, 0, -1, '0);
      idle(1);

      // Zero operand, then a back-to-back request with valid kept high
      run_op(32'h0000_0000, 32'h0000_1234, 1'b0, 64'd0, 0, 0, -1, '0);
      run_op(32'h0000_0007, 32'h0000_0006, 1'b0, 64'd42, 0, 0, -1, '0);
      idle(1);

      // Operand change during BUSY is ignored
      run_op(32'd3, 32'd5, 1'b0, 64'd15, 0, 0, 10, 32'hDEAD_BEEF);
      idle(1);

      // Annul at cycle 12: no ready, result keeps 15, next op has full latency
      run_op(32'd5, 32'd5, 1'b0, 64'd25, 1, 12, -1, '0);
      idle(3);
      run_op(32'd9, 32'd9, 1'b0, 64'd81, 0, 0, -1, '0);
      idle(1);

      // Reset at cycle 20: result clears, no ready
      run_op(32'd100, 32'd100, 1'b0, 64'd10000, 2, 20, -1, '0);
      last_res = '0;
      idle(2);
      run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 0, 0, -1, '0);
      idle(1);

      final_chk = 1'b1;
      adv();
      final_chk = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_mult_seq
`default_nettype wire
